// File: rtl/maq_pkg.sv
// Shared types, limits and BCD increment helpers for the minutes/hours clock stage.
package maq_pkg;

  typedef enum logic [1:0] {
    MODO_RUN      = 2'd0,
    MODO_SET_HORA = 2'd1,
    MODO_SET_MIN  = 2'd2
  } modo_t;

  localparam logic [2:0] MAX_MIN_MSD     = 3'd5;
  localparam logic [1:0] MAX_HORA_MSD    = 2'd2;
  localparam logic [3:0] MAX_HORA_LSD_23 = 4'd3;

  typedef struct packed {
    logic [2:0] msd;
    logic [3:0] lsd;
  } min_t;

  typedef struct packed {
    logic [1:0] msd;
    logic [3:0] lsd;
  } hora_t;

  // 59 wraps to 00; the caller decides whether that carries into hours.
  function automatic min_t min_inc(input min_t m);
    min_t r;
    r = m;
    if (m.lsd == 4'd9) begin
      r.lsd = 4'd0;
      r.msd = (m.msd == MAX_MIN_MSD) ? 3'd0 : m.msd + 3'd1;
    end else begin
      r.lsd = m.lsd + 4'd1;
    end
    return r;
  endfunction

  function automatic logic min_at_max(input min_t m);
    return (m.msd == MAX_MIN_MSD) && (m.lsd == 4'd9);
  endfunction

  function automatic hora_t hora_inc(input hora_t h);
    hora_t r;
    r = h;
    if ((h.msd == MAX_HORA_MSD) && (h.lsd == MAX_HORA_LSD_23)) begin
      r.msd = 2'd0;
      r.lsd = 4'd0;
    end else if (h.lsd == 4'd9) begin
      r.lsd = 4'd0;
      r.msd = h.msd + 2'd1;
    end else begin
      r.lsd = h.lsd + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/maq_borda.sv
// One-bit rising-edge detector; history resets to 1 so a level held through reset is not an edge.
module maq_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b1;
    else        btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/maq_mh.sv
// Minutes/hours BCD counter with a button-driven time-setting FSM.
// Optional hold-to-repeat on the adjust button is enabled with MAQMH_AUTOREPEAT_EN.
module maq_mh
  import maq_pkg::*;
#(
  parameter int HORA_INICIAL = 0,
  parameter int MIN_INICIAL  = 0,
  parameter int REPEAT_DELAY = 2
) (
  input  logic       maqmh_clock,
  input  logic       maqmh_reset,
  input  logic       maqmh_enable,
  input  logic       maqmh_incrementa_minuto,
  input  logic       maqmh_btn_modo,
  input  logic       maqmh_btn_ajuste,
  output logic [3:0] maqmh_min_lsd,
  output logic [2:0] maqmh_min_msd,
  output logic [3:0] maqmh_hora_lsd,
  output logic [1:0] maqmh_hora_msd,
  output logic [1:0] maqmh_modo,
  output logic       maqmh_zera_segundos
);

  localparam min_t  MIN_RST  = {3'(MIN_INICIAL / 10), 4'(MIN_INICIAL % 10)};
  localparam hora_t HORA_RST = {2'(HORA_INICIAL / 10), 4'(HORA_INICIAL % 10)};

  // Valid/ready-free block: every input is a level or one-cycle tick sampled on
  // the clock; outputs are registered and change one clock after the qualifying input.

  modo_t modo;
  min_t  min;
  hora_t hora;
  logic  zera;
  logic  modo_rise;
  logic  ajuste_rise;
  logic  ajuste_step;
  logic  advance;

  maq_borda u_borda_modo (
    .clk   (maqmh_clock),
    .rst_n (maqmh_reset),
    .btn   (maqmh_btn_modo),
    .rise  (modo_rise)
  );

  maq_borda u_borda_ajuste (
    .clk   (maqmh_clock),
    .rst_n (maqmh_reset),
    .btn   (maqmh_btn_ajuste),
    .rise  (ajuste_rise)
  );

  assign advance = maqmh_enable & maqmh_incrementa_minuto;

`ifdef MAQMH_AUTOREPEAT_EN
  logic [7:0] hold_cnt;
  logic       repeat_step;

  // Counts enable ticks with ajuste held; saturates at REPEAT_DELAY, then each tick repeats.
  always_ff @(posedge maqmh_clock or negedge maqmh_reset) begin
    if (!maqmh_reset) begin
      hold_cnt <= '0;
    end else if (!maqmh_btn_ajuste || modo_rise || (modo == MODO_RUN)) begin
      hold_cnt <= '0;
    end else if (maqmh_enable && (hold_cnt < 8'(REPEAT_DELAY))) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign repeat_step = maqmh_enable & maqmh_btn_ajuste & (hold_cnt >= 8'(REPEAT_DELAY));
  assign ajuste_step = ajuste_rise | repeat_step;
`else
  localparam int unused_repeat_delay = REPEAT_DELAY;
  assign ajuste_step = ajuste_rise;
`endif

  // A mode-button edge always wins over an adjust action in the same cycle.
  always_ff @(posedge maqmh_clock or negedge maqmh_reset) begin
    if (!maqmh_reset) begin
      modo <= MODO_RUN;
      min  <= MIN_RST;
      hora <= HORA_RST;
      zera <= 1'b0;
    end else begin
      zera <= 1'b0;
      case (modo)
        MODO_RUN: begin
          if (advance) begin
            min <= min_inc(min);
            if (min_at_max(min)) hora <= hora_inc(hora);
          end
          if (modo_rise) modo <= MODO_SET_HORA;
        end
        MODO_SET_HORA: begin
          if (modo_rise)        modo <= MODO_SET_MIN;
          else if (ajuste_step) hora <= hora_inc(hora);
        end
        MODO_SET_MIN: begin
          if (modo_rise) begin
            modo <= MODO_RUN;
            zera <= 1'b1;
          end else if (ajuste_step) begin
            min <= min_inc(min);
          end
        end
        default: modo <= MODO_RUN;
      endcase
    end
  end

  assign maqmh_min_lsd       = min.lsd;
  assign maqmh_min_msd       = min.msd;
  assign maqmh_hora_lsd      = hora.lsd;
  assign maqmh_hora_msd      = hora.msd;
  assign maqmh_modo          = modo;
  assign maqmh_zera_segundos = zera;

endmodule

// File: tb/tb_maq_mh.sv
// Scoreboard bench for maq_mh: driver pushes expected {hh,mm,modo,zera}; monitor compares at negedge.
module tb_maq_mh;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       incrementa;
  logic       btn_modo;
  logic       btn_ajuste;
  logic [3:0] min_lsd;
  logic [2:0] min_msd;
  logic [3:0] hora_lsd;
  logic [1:0] hora_msd;
  logic [1:0] modo;
  logic       zera;

  maq_mh dut (
    .maqmh_clock             (clk),
    .maqmh_reset             (rst_n),
    .maqmh_enable            (enable),
    .maqmh_incrementa_minuto (incrementa),
    .maqmh_btn_modo          (btn_modo),
    .maqmh_btn_ajuste        (btn_ajuste),
    .maqmh_min_lsd           (min_lsd),
    .maqmh_min_msd           (min_msd),
    .maqmh_hora_lsd          (hora_lsd),
    .maqmh_hora_msd          (hora_msd),
    .maqmh_modo              (modo),
    .maqmh_zera_segundos     (zera)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard
  localparam int W = 16;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int total = 0;
  int bad = 0;
  int zera_seen = 0;
  int zera_exp = 0;
  int cur_h = 0;
  int cur_m = 0;
  bit done = 1'b0;
  bit reported = 1'b0;

  function automatic logic [W-1:0] exp_vec(input int h, input int m, input int md, input bit z);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 2'(md), z};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    string nm;
    act = {hora_msd, hora_lsd, min_msd, min_lsd, modo, zera};
    if (zera === 1'b1) zera_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %0d%0d:%0d%0d modo=%0d zera=%0d, expected %0d%0d:%0d%0d modo=%0d zera=%0d",
                 nm, act[15:14], act[13:10], act[9:7], act[6:3], act[2:1], act[0],
                 e[15:14], e[13:10], e[9:7], e[6:3], e[2:1], e[0]);
      end
    end else if (done && !reported) begin
      reported = 1'b1;
      total++;
      if (zera_seen != zera_exp) begin
        bad++;
        $display("FAIL zera_pulse_count: got %0d expected %0d", zera_seen, zera_exp);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int h, input int m, input int md, input bit z, input string nm);
    exp_q.push_back(exp_vec(h, m, md, z));
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_modo();
    btn_modo = 1'b1;
    cyc();
    btn_modo = 1'b0;
    cyc();
  endtask

  task automatic pulse_ajuste();
    btn_ajuste = 1'b1;
    cyc();
    btn_ajuste = 1'b0;
    cyc();
  endtask

  task automatic advance();
    incrementa = 1'b1;
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    incrementa = 1'b0;
  endtask

  // RUN -> SET_HORA -> SET_MIN -> RUN, stepping each field to the target.
  task automatic set_time(input int h, input int m, input string nm);
    pulse_modo();
    repeat ((h - cur_h + 24) % 24) pulse_ajuste();
    pulse_modo();
    repeat ((m - cur_m + 60) % 60) pulse_ajuste();
    pulse_modo();
    zera_exp++;
    cur_h = h;
    cur_m = m;
    expect_now(h, m, 0, 1'b0, nm);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    incrementa = 1'b0;
    btn_modo = 1'b1;
    btn_ajuste = 1'b0;
    cyc();
    expect_now(0, 0, 0, 1'b0, "reset_state");
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    expect_now(0, 0, 0, 1'b0, "modo_held_through_reset");
    btn_modo = 1'b0;
    cyc();

    // carry level held 5 cycles with one enable tick advances exactly one minute
    set_time(0, 59, "set_0059");
    incrementa = 1'b1;
    cyc();
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    expect_now(1, 0, 0, 1'b0, "advance_0059");
    cyc(); cyc(); cyc();
    incrementa = 1'b0;
    expect_now(1, 0, 0, 1'b0, "carry_level_only");
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    expect_now(1, 0, 0, 1'b0, "enable_only");
    cur_h = 1; cur_m = 0;

    set_time(9, 59, "set_0959");
    advance();
    expect_now(10, 0, 0, 1'b0, "advance_0959");
    cur_h = 10; cur_m = 0;
    set_time(19, 59, "set_1959");
    advance();
    expect_now(20, 0, 0, 1'b0, "advance_1959");
    cur_h = 20; cur_m = 0;
    set_time(23, 59, "set_2359");
    advance();
    expect_now(0, 0, 0, 1'b0, "advance_2359");
    cur_h = 0; cur_m = 0;

    // hour setting sweep with wrap
    set_time(22, 58, "set_2258");
    pulse_modo();
    expect_now(22, 58, 1, 1'b0, "enter_set_hora");
    for (int i = 1; i <= 25; i++) begin
      pulse_ajuste();
      expect_now((22 + i) % 24, 58, 1, 1'b0, "set_hora_step");
    end
    advance();
    expect_now(23, 58, 1, 1'b0, "set_hora_carry_ignored");
    btn_modo = 1'b1;
    btn_ajuste = 1'b1;
    cyc();
    expect_now(23, 58, 2, 1'b0, "modo_wins_over_ajuste");
    btn_modo = 1'b0;
    btn_ajuste = 1'b0;
    cyc();

    // minute setting sweep, no carry into hours
    for (int i = 1; i <= 61; i++) begin
      pulse_ajuste();
      expect_now(23, (58 + i) % 60, 2, 1'b0, "set_min_step");
    end
    advance();
    expect_now(23, 59, 2, 1'b0, "set_min_carry_ignored");
    btn_modo = 1'b1;
    cyc();
    zera_exp++;
    expect_now(23, 59, 0, 1'b1, "zera_on_exit");
    btn_modo = 1'b0;
    cyc();
    expect_now(23, 59, 0, 1'b0, "zera_one_cycle");

    // advance and mode change in the same cycle
    btn_modo = 1'b1;
    incrementa = 1'b1;
    enable = 1'b1;
    cyc();
    expect_now(0, 0, 1, 1'b0, "advance_with_modo_rise");
    btn_modo = 1'b0;
    incrementa = 1'b0;
    enable = 1'b0;
    cyc();
    pulse_modo();
    repeat (3) pulse_ajuste();
    expect_now(0, 3, 2, 1'b0, "set_min_before_reset");

    // asynchronous reset in the middle of setting
    cyc();
    rst_n = 1'b0;
    expect_now(0, 0, 0, 1'b0, "async_reset_mid_set");
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    expect_now(0, 0, 0, 1'b0, "after_reset_release");
    cur_h = 0; cur_m = 0;

`ifdef MAQMH_AUTOREPEAT_EN
    pulse_modo();
    pulse_modo();
    repeat (10) pulse_ajuste();
    expect_now(0, 10, 2, 1'b0, "autorepeat_start");
    btn_ajuste = 1'b1;
    cyc();
    repeat (6) begin
      enable = 1'b1;
      cyc();
      enable = 1'b0;
      cyc();
    end
    btn_ajuste = 1'b0;
    cyc();
    expect_now(0, 15, 2, 1'b0, "autorepeat_hold");
    pulse_modo();
    zera_exp++;
    expect_now(0, 15, 0, 1'b0, "autorepeat_exit");
`endif

    cyc();
    done = 1'b1;
  end

endmodule

// File: doc/maq_mh.md
Name: maq_mh

Overview:
- Minutes/hours stage directly downstream of the seconds counter (maq_s).
- Consumes the seconds stage's minute-carry and the same 1 Hz enable tick; keeps minutes 00–59 and hours 00–23 as BCD digit pairs for the display decoders.
- Adds a time-setting mode FSM driven by two debounced push-buttons (modo, ajuste).
- Asks the seconds stage to clear when setting finishes.

Parameters:
- HORA_INICIAL, 0, hour loaded at reset (0–23, binary).
- MIN_INICIAL, 0, minute loaded at reset (0–59, binary).
- REPEAT_DELAY, 2, enable ticks that ajuste must be held before auto-repeat starts (used only with MAQMH_AUTOREPEAT_EN).

Ports:
- maqmh_clock  input  1  system clock.
- maqmh_reset  input  1  asynchronous, active-low reset.
- maqmh_enable  input  1  one-cycle tick; the same signal that drives the seconds stage enable.
- maqmh_incrementa_minuto  input  1  seconds stage carry, a level high for the whole of second 59.
- maqmh_btn_modo  input  1  synchronized, debounced mode button; active-high level.
- maqmh_btn_ajuste  input  1  synchronized, debounced adjust button; active-high level.
- maqmh_min_lsd  output  4  minute units, BCD 0–9.
- maqmh_min_msd  output  3  minute tens, 0–5.
- maqmh_hora_lsd  output  4  hour units, BCD 0–9.
- maqmh_hora_msd  output  2  hour tens, 0–2.
- maqmh_modo  output  2  current mode, encoded as maq_pkg::modo_t.
- maqmh_zera_segundos  output  1  one-cycle pulse requesting the seconds stage to reset.

Behaviour:
- Reset (maqmh_reset=0, asynchronous):
  - Digits load HORA_INICIAL:MIN_INICIAL split into BCD.
  - modo=MODO_RUN, zera_segundos=0.
  - Both button history flops set to 1, so a button held through reset produces no edge.
- Button edges: rise = btn & ~btn_q, with btn_q registered every cycle. All edge-driven actions take effect on the clock after the rising level is sampled.
- Minute advance (MODO_RUN): only when enable && incrementa_minuto in the same cycle. The carry level alone never advances.
- Minute counting: lsd 9→0 with msd+1; 59→00 carries one hour.
- Hour counting: lsd 9→0 with msd+1, except 23→00. Hence 23:59 + advance → 00:00. BCD only; illegal codes are unreachable.
- FSM states: MODO_RUN=0, MODO_SET_HORA=1, MODO_SET_MIN=2. Encoding 3 is illegal and recovers to MODO_RUN on the next clock.
- FSM transitions on rise of modo: RUN→SET_HORA→SET_MIN→RUN.
- SET_HORA:
  - Rise of ajuste → hour+1 with wrap 23→00.
  - Minutes frozen.
  - Carry inputs ignored; lost minutes are accepted.
- SET_MIN:
  - Rise of ajuste → minute+1 with wrap 59→00 and no carry into hours.
  - Hours frozen.
  - Carry inputs ignored.
- zera_segundos: high for exactly the one cycle in which maqmh_modo changes SET_MIN→RUN; 0 otherwise.
- Simultaneous events:
  - modo rise and ajuste rise in the same cycle: mode change wins, ajuste is discarded.
  - RUN with advance condition and modo rise in the same cycle: the minute advance is applied and the mode changes to SET_HORA.
- Latency: all outputs are registered, one clock after the qualifying input.
- Reset asserted mid-setting returns to MODO_RUN at the initial time immediately, without a zera_segundos pulse.

Optional Feature:
- Macro MAQMH_AUTOREPEAT_EN.
- Defined:
  - In SET_HORA/SET_MIN, a hold counter counts enable ticks while ajuste stays high.
  - Once the count reaches REPEAT_DELAY, every further enable tick with ajuste high also increments the active field.
  - The counter clears when ajuste is low or on any mode change.
  - The initial rise still increments once.
- Undefined: only rising edges increment. No hold counter is built.

Decomposition:
- Package maq_pkg holds:
  - typedef enum logic [1:0] modo_t {MODO_RUN, MODO_SET_HORA, MODO_SET_MIN}.
  - Constants MAX_MIN_MSD=5, MAX_HORA_MSD=2, MAX_HORA_LSD_23=3.
- Sub-module maq_borda: a one-bit rising-edge detector with reset-to-1 history flop, instantiated twice (modo, ajuste).

Test Plan:
- Reset with defaults → 00:00, modo=0, zera=0. Release reset, hold btn_modo=1 → modo stays 0.
- RUN at 00:59, incrementa_minuto=1 for 5 cycles with a single enable pulse → exactly 01:00, not 05:00.
- RUN at 23:59, enable && incrementa → 00:00. Also check 09:59 → 10:00 and 19:59 → 20:00.
- Three modo pulses from RUN:
  - modo goes 1, 2, 0.
  - In SET_HORA, 25 ajuste pulses from 22 → hour 23, then 00…23, ending at 23.
  - In SET_MIN, 61 pulses from 58 with hour unchanged → 59.
  - zera pulses once, on the SET_MIN→RUN transition.
- SET_HORA with enable && incrementa asserted → time unchanged. modo and ajuste rising in the same cycle → modo advances, hour unchanged.
- Reset pulled low mid-SET_MIN → asynchronously returns to 00:00, modo=0, zera never pulses. With MAQMH_AUTOREPEAT_EN, REPEAT_DELAY=2, ajuste held 6 ticks in SET_MIN from 10 → 15.
